bin2bcd_control: RTL and testbench

Sequential binary-to-BCD converter that feeds the six-digit seven-segment scan stage. It takes a 20-bit unsigned value from the SPI receive path and converts it by shift-and-add-3 (double dabble), one bit per clock. It then presents a held 24-bit packed-BCD word (six digits, most significant digit in bits [23:20]) as `Number_Sig` to the digit scanner. Values above 999999 saturate to 999999 and raise an overflow flag.

---
 rtl/bin2bcd_control.sv | 87 ++++++++
 tb/tb_bin2bcd_control.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_control.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that
// hands a held, saturated six-digit packed-BCD word to the seven-segment scanner.
module bin2bcd_control #(
    parameter int                BIN_W   = 20,
    parameter logic [BIN_W-1:0]  MAX_VAL = 20'd999999
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             Start_Sig,
    input  logic [BIN_W-1:0] Bin_Data,
    output logic [23:0]      Number_Sig,
    output logic             Done_Sig,
    output logic             Busy_Sig,
    output logic             Over_Sig
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [BIN_W-1:0] rBin;
    logic [23:0]      rBcd;
    logic [4:0]       rCnt;
    logic             rOver;
    logic [23:0]      bcd_adj;

    // Nibbles never exceed 9 before the adjust, so 4-bit wraparound cannot occur.
    function automatic logic [23:0] add3(input logic [23:0] bcd);
        logic [23:0] res;
        logic [3:0]  nib;
        res = bcd;
        for (int d = 0; d < 6; d++) begin
            nib = bcd[4*d +: 4];
            if (nib >= 4'd5)
                res[4*d +: 4] = nib + 4'd3;
        end
        return res;
    endfunction

    assign bcd_adj  = add3(rBcd);
    assign Busy_Sig = (state != IDLE);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            rBin       <= '0;
            rBcd       <= '0;
            rCnt       <= '0;
            rOver      <= 1'b0;
            Number_Sig <= '0;
            Done_Sig   <= 1'b0;
            Over_Sig   <= 1'b0;
        end else begin
            Done_Sig <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start_Sig) begin
                        rBin  <= Bin_Data;
                        rBcd  <= '0;
                        rCnt  <= '0;
                        rOver <= (Bin_Data > MAX_VAL);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    rBcd <= {bcd_adj[22:0], rBin[BIN_W-1]};
                    rBin <= {rBin[BIN_W-2:0], 1'b0};
                    rCnt <= rCnt + 5'd1;
                    if (rCnt == 5'(BIN_W - 1))
                        state <= DONE;
                end
                DONE: begin
                    // Outputs move only here, so the scanner never sees a partial word.
                    Number_Sig <= rOver ? 24'h999999 : rBcd;
                    Over_Sig   <= rOver;
                    Done_Sig   <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_control.sv
// Scoreboard bench for bin2bcd_control: stimulus queues expected results,
// a monitor compares them against each Done_Sig pulse.
module tb_bin2bcd_control;

    logic        CLK;
    logic        RSTn;
    logic        Start_Sig;
    logic [19:0] Bin_Data;
    logic [23:0] Number_Sig;
    logic        Done_Sig;
    logic        Busy_Sig;
    logic        Over_Sig;

    typedef struct {
        logic [23:0] num;
        logic        over;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    bin2bcd_control dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .Start_Sig  (Start_Sig),
        .Bin_Data   (Bin_Data),
        .Number_Sig (Number_Sig),
        .Done_Sig   (Done_Sig),
        .Busy_Sig   (Busy_Sig),
        .Over_Sig   (Over_Sig)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Reference conversion by repeated division, independent of double dabble.
    function automatic logic [23:0] to_bcd(input logic [19:0] v);
        logic [23:0] r;
        int          x;
        x = int'(v);
        if (x > 999999) return 24'h999999;
        r = '0;
        for (int d = 0; d < 6; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every Done pulse must match the oldest pending expectation.
    always @(negedge CLK) begin
        if (Done_Sig) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got Done_Sig=1 expected no pending result (cyc %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("number", 32'(Number_Sig), 32'(e.num));
                check("over", 32'(Over_Sig), 32'(e.over));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (Busy_Sig && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (Busy_Sig) check("idle_timeout", 32'(Busy_Sig), 32'd0);
    endtask

    // Drives a one-cycle request; returns at the negedge after the accepting edge k.
    task automatic issue(input logic [19:0] val, input logic [23:0] num, input logic over);
        exp_t e;
        wait_idle();
        Start_Sig = 1'b1;
        Bin_Data  = val;
        e.num  = num;
        e.over = over;
        e.cyc  = cyc + 1 + 21;
        exp_q.push_back(e);
        @(negedge CLK);
        Start_Sig = 1'b0;
        Bin_Data  = 20'(~val);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        int          n;
        logic [19:0] v;
        exp_t        e;
        RSTn      = 1'b0;
        Start_Sig = 1'b0;
        Bin_Data  = '0;
        repeat (3) @(negedge CLK);
        check("rst_number", 32'(Number_Sig), 32'd0);
        check("rst_done", 32'(Done_Sig), 32'd0);
        check("rst_busy", 32'(Busy_Sig), 32'd0);
        check("rst_over", 32'(Over_Sig), 32'd0);
        RSTn = 1'b1;
        @(negedge CLK);

        issue(20'd0, 24'h000000, 1'b0);
        drain();

        issue(20'd123456, 24'h123456, 1'b0);
        n = 0;
        while (Busy_Sig && n < 100) begin
            n++;
            @(negedge CLK);
        end
        check("busy_cycles", 32'(n), 32'd21);
        drain();

        issue(20'd999999, 24'h999999, 1'b0);
        issue(20'd1000000, 24'h999999, 1'b1);
        issue(20'hFFFFF, 24'h999999, 1'b1);
        drain();

        // Second request lands in SHIFT at k+5 and must be dropped.
        issue(20'd42, 24'h000042, 1'b0);
        repeat (4) @(negedge CLK);
        Start_Sig = 1'b1;
        Bin_Data  = 20'd777;
        @(negedge CLK);
        Start_Sig = 1'b0;
        drain();

        // Start held high: captures at k, k+22, k+44.
        wait_idle();
        Start_Sig = 1'b1;
        Bin_Data  = 20'd9;
        for (int j = 0; j < 3; j++) begin
            e.num  = 24'h000009;
            e.over = 1'b0;
            e.cyc  = cyc + 1 + 22 * j + 21;
            exp_q.push_back(e);
        end
        repeat (45) @(negedge CLK);
        Start_Sig = 1'b0;
        drain();

        issue(20'd555555, 24'h555555, 1'b0);
        drain();
        issue(20'd31, 24'h000031, 1'b0);
        repeat (9) @(negedge CLK);
        #5;
        RSTn = 1'b0;
        exp_q.delete();
        #1;
        check("abort_number", 32'(Number_Sig), 32'd0);
        check("abort_done", 32'(Done_Sig), 32'd0);
        check("abort_busy", 32'(Busy_Sig), 32'd0);
        check("abort_over", 32'(Over_Sig), 32'd0);
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        repeat (30) @(negedge CLK);
        issue(20'd31, 24'h000031, 1'b0);
        drain();

        for (int j = 0; j < 2000; j++) begin
            v = 20'($urandom_range(0, 1048575));
            issue(v, to_bcd(v), (v > 20'd999999));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
